// File: rtl/uart_rx_16x_if.sv
// Serial-in / byte-out bundle between the RX pin logic and the image-buffer loader.
// Latency: none, wires only.
// Backpressure: none; the consumer acknowledges with rdy_clr, unacknowledged bytes get overwritten.
interface uart_rx_16x_if #(
   parameter int DATA_BITS = 8
);
   logic                 rx;
   logic                 rxclk_en;
   logic                 rdy_clr;
   logic [DATA_BITS-1:0] data;
   logic                 rdy;
   logic                 frame_err;
   logic                 busy;

   // line/strobe/ack source side (pin, baud generator, consumer)
   modport master (
      output rx, rxclk_en, rdy_clr,
      input  data, rdy, frame_err, busy
   );

   // receiver side
   modport slave (
      input  rx, rxclk_en, rdy_clr,
      output data, rdy, frame_err, busy
   );
endinterface

// File: rtl/uart_rx_16x.sv
// UART 8N1 receiver: centre-samples rx using the oversample strobe rxclk_en.
// Latency: ~9.5 bit times from start edge to rdy, plus up to one strobe period plus 3 clocks.
// Backpressure: none; rdy is sticky until rdy_clr, and a new byte overwrites data (overrun).
module uart_rx_16x #(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8
) (
   input  logic          clk_50m,
   input  logic          rst_n,
   uart_rx_16x_if.slave  rx_if
);
   localparam int SMP_W = $clog2(OVERSAMPLE);
   localparam int BIT_W = $clog2(DATA_BITS) + 1;

   localparam logic [SMP_W-1:0] SMP_HALF = SMP_W'(OVERSAMPLE / 2 - 1);
   localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(OVERSAMPLE - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic                 rx_meta;
   logic                 rx_s;
   logic [1:0]           state;
   logic [SMP_W-1:0]     smp;
   logic [BIT_W-1:0]     bitn;
   logic [DATA_BITS-1:0] sh;
   logic [DATA_BITS-1:0] data_q;
   logic                 rdy_q;
   logic                 frame_err_q;
   logic                 mid_stop;
   logic                 rdy_set;

   // Sample point of the stop bit; data/rdy/frame_err all update here.
   assign mid_stop = rx_if.rxclk_en && (state == STOP) && (smp == SMP_LAST);
   assign rdy_set  = mid_stop && rx_s;

   // Two-flop synchronizer for the asynchronous line; idles high.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx_if.rx;
         rx_s    <= rx_meta;
      end
   end

   // Frame FSM with tick and bit counters; advances only on strobe cycles.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         smp   <= '0;
         bitn  <= '0;
         sh    <= '0;
      end else if (rx_if.rxclk_en) begin
         case (state)
            IDLE: begin
               if (!rx_s) begin
                  smp   <= '0;
                  state <= START;
               end
            end
            START: begin
               if (smp == SMP_HALF) begin
                  // Still low at mid start bit: real frame. High: glitch, drop it silently.
                  if (!rx_s) begin
                     smp   <= '0;
                     bitn  <= '0;
                     state <= DATA;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  smp <= smp + SMP_W'(1);
               end
            end
            DATA: begin
               if (smp == SMP_LAST) begin
                  sh   <= {rx_s, sh[DATA_BITS-1:1]};
                  smp  <= '0;
                  bitn <= bitn + BIT_W'(1);
                  if (bitn == BIT_LAST) begin
                     state <= STOP;
                  end
               end else begin
                  smp <= smp + SMP_W'(1);
               end
            end
            default: begin
               // Re-arm at mid stop bit so a start edge in the last half bit is caught.
               if (smp == SMP_LAST) begin
                  smp   <= '0;
                  state <= IDLE;
               end else begin
                  smp <= smp + SMP_W'(1);
               end
            end
         endcase
      end
   end

   // Byte and framing-error capture at mid stop bit; a bad stop keeps the old byte.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         data_q      <= '0;
         frame_err_q <= 1'b0;
      end else if (mid_stop) begin
         if (rx_s) begin
            data_q      <= sh;
            frame_err_q <= 1'b0;
         end else begin
            frame_err_q <= 1'b1;
         end
      end
   end

   // Sticky ready flag; a set on the same edge as a clear wins.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q <= 1'b0;
      end else if (rdy_set) begin
         rdy_q <= 1'b1;
      end else if (rx_if.rdy_clr) begin
         rdy_q <= 1'b0;
      end
   end

   assign rx_if.data      = data_q;
   assign rx_if.rdy       = rdy_q;
   assign rx_if.frame_err = frame_err_q;
   assign rx_if.busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_16x.sv
// Directed bench for uart_rx_16x: 1-in-28 strobe, 434 clocks per bit (about 3% fast line).
// Latency: each frame is 4340 clocks on the line; results are sampled at frame end.
// Backpressure: the bench acknowledges bytes with rdy_clr pulses where the scenario asks for it.
`timescale 1ns/1ps
module tb_uart_rx_16x;
   localparam int BIT_CLKS = 434;
   localparam int TICK     = 28;

   logic clk_50m;
   logic rst_n;
   int   total;
   int   bad;

   uart_rx_16x_if #(.DATA_BITS(8)) u_if ();

   uart_rx_16x #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
      .clk_50m (clk_50m),
      .rst_n   (rst_n),
      .rx_if   (u_if)
   );

   initial clk_50m = 1'b0;
   always #10 clk_50m = ~clk_50m;

   // Oversample strobe: one clock high every TICK clocks.
   initial begin
      u_if.rxclk_en = 1'b0;
      forever begin
         repeat (TICK - 1) @(negedge clk_50m);
         u_if.rxclk_en = 1'b1;
         @(negedge clk_50m);
         u_if.rxclk_en = 1'b0;
      end
   end

   // Hard time limit so the run always ends.
   initial begin
      #5ms;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk_50m);
   endtask

   // One 8N1 frame. clr_first pulses rdy_clr on the first clock of the start bit;
   // collide holds rdy_clr through the stop bit until rdy is seen high.
   task automatic send_byte(input logic [7:0] b, input logic stop_v,
                            input bit clr_first, input bit collide);
      u_if.rx      = 1'b0;
      u_if.rdy_clr = clr_first;
      @(negedge clk_50m);
      u_if.rdy_clr = 1'b0;
      wait_clks(BIT_CLKS - 1);
      for (int i = 0; i < 8; i++) begin
         u_if.rx = b[i];
         wait_clks(BIT_CLKS);
      end
      u_if.rx      = stop_v;
      u_if.rdy_clr = collide;
      for (int i = 0; i < BIT_CLKS; i++) begin
         @(negedge clk_50m);
         if (u_if.rdy_clr && u_if.rdy) u_if.rdy_clr = 1'b0;
      end
   endtask

   task automatic pulse_clr();
      u_if.rdy_clr = 1'b1;
      @(negedge clk_50m);
      u_if.rdy_clr = 1'b0;
   endtask

   logic [7:0] seq [3];

   initial begin
      total        = 0;
      bad          = 0;
      rst_n        = 1'b0;
      u_if.rx      = 1'b1;
      u_if.rdy_clr = 1'b0;
      seq[0] = 8'h00;
      seq[1] = 8'hFF;
      seq[2] = 8'h55;
      wait_clks(5);
      chk("rst_data", u_if.data, 8'h00);
      chk("rst_rdy", u_if.rdy, 1'b0);
      chk("rst_ferr", u_if.frame_err, 1'b0);
      chk("rst_busy", u_if.busy, 1'b0);
      rst_n = 1'b1;
      wait_clks(100);

      // basic byte and acknowledge
      send_byte(8'hA5, 1'b1, 1'b0, 1'b0);
      chk("a5_data", u_if.data, 8'hA5);
      chk("a5_rdy", u_if.rdy, 1'b1);
      chk("a5_ferr", u_if.frame_err, 1'b0);
      pulse_clr();
      chk("a5_clr", u_if.rdy, 1'b0);

      // back-to-back bytes, each acknowledged at the next start bit
      for (int i = 0; i < 3; i++) begin
         send_byte(seq[i], 1'b1, (i != 0), 1'b0);
         chk($sformatf("b2b%0d_data", i), u_if.data, seq[i]);
         chk($sformatf("b2b%0d_rdy", i), u_if.rdy, 1'b1);
         chk($sformatf("b2b%0d_ferr", i), u_if.frame_err, 1'b0);
      end
      pulse_clr();
      chk("b2b_clr", u_if.rdy, 1'b0);
      wait_clks(200);

      // glitch: 5 strobe ticks low
      u_if.rx = 1'b0;
      wait_clks(3 * TICK);
      chk("glitch_busy_hi", u_if.busy, 1'b1);
      wait_clks(2 * TICK);
      u_if.rx = 1'b1;
      wait_clks(20 * TICK);
      chk("glitch_busy_lo", u_if.busy, 1'b0);
      chk("glitch_rdy", u_if.rdy, 1'b0);
      chk("glitch_ferr", u_if.frame_err, 1'b0);

      // framing error keeps the old byte, then a good frame clears the error
      send_byte(8'h3C, 1'b0, 1'b0, 1'b0);
      u_if.rx = 1'b1;
      chk("fe_ferr", u_if.frame_err, 1'b1);
      chk("fe_rdy", u_if.rdy, 1'b0);
      chk("fe_data", u_if.data, 8'h55);
      wait_clks(600);
      chk("fe_idle", u_if.busy, 1'b0);
      send_byte(8'h81, 1'b1, 1'b0, 1'b0);
      chk("81_ferr", u_if.frame_err, 1'b0);
      chk("81_data", u_if.data, 8'h81);
      chk("81_rdy", u_if.rdy, 1'b1);
      pulse_clr();
      chk("81_clr", u_if.rdy, 1'b0);

      // set/clear collision, then overrun without acknowledge
      send_byte(8'h96, 1'b1, 1'b0, 1'b1);
      chk("coll_seen", u_if.rdy_clr, 1'b0);
      u_if.rdy_clr = 1'b0;
      chk("coll_rdy", u_if.rdy, 1'b1);
      chk("coll_data", u_if.data, 8'h96);
      send_byte(8'h12, 1'b1, 1'b0, 1'b0);
      chk("ovr_data", u_if.data, 8'h12);
      chk("ovr_rdy", u_if.rdy, 1'b1);

      // reset during data bit 4 of 0xC3
      u_if.rx = 1'b0;
      wait_clks(BIT_CLKS);
      for (int i = 0; i < 4; i++) begin
         u_if.rx = (i < 2);
         wait_clks(BIT_CLKS);
      end
      u_if.rx = 1'b0;
      wait_clks(200);
      chk("mid_busy", u_if.busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mrst_data", u_if.data, 8'h00);
      chk("mrst_rdy", u_if.rdy, 1'b0);
      chk("mrst_ferr", u_if.frame_err, 1'b0);
      chk("mrst_busy", u_if.busy, 1'b0);
      u_if.rx = 1'b1;
      wait_clks(10);
      rst_n = 1'b1;
      wait_clks(300);
      send_byte(8'h7E, 1'b1, 1'b0, 1'b0);
      chk("7e_data", u_if.data, 8'h7E);
      chk("7e_rdy", u_if.rdy, 1'b1);
      chk("7e_ferr", u_if.frame_err, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
